tlp_tx_arbiter: RTL

//  Packet-level arbiter that merges PORTS TLP source streams (read-completion path, write path, ...) onto one
//  TLP TX stream toward the PCIe core. Grants one port from sop to eop, never interleaving beats of different

---
 rtl/tlp_pkg.sv | 23 ++
 rtl/tlp_skid_buf.sv | 48 ++++
 rtl/tlp_tx_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tlp_pkg.sv
// Shared TLP definitions: field widths, FMT/TYPE codes and the TX arbiter state encoding.
package tlp_pkg;

    localparam int DOUBLE_WORD  = 32;
    localparam int HEADER_SIZE  = 4 * DOUBLE_WORD;
    localparam int PAYLOAD_SIZE = 8 * DOUBLE_WORD;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

    // MRd and MWr share a TYPE code; FMT tells them apart.
    localparam logic [4:0] TYPE_MRD  = 5'b00000;
    localparam logic [4:0] TYPE_MWR  = 5'b00000;
    localparam logic [4:0] TYPE_CPLD = 5'b01010;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tlp_skid_buf.sv
// Two-entry registered output stage: main register drives the outputs, skid register absorbs
// the beat accepted in the cycle downstream stalls. Upstream ready depends only on skid state.
module tlp_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic [W-1:0] main_q;
    logic         main_v_q;
    logic [W-1:0] skid_q;
    logic         skid_v_q;

    assign s_ready_o = ~skid_v_q;
    assign m_data_o  = main_q;
    assign m_valid_o = main_v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else if (!main_v_q || m_ready_i) begin
            if (skid_v_q) begin
                main_q   <= skid_q;
                main_v_q <= 1'b1;
                skid_v_q <= 1'b0;
            end else begin
                main_v_q <= s_valid_i;
                if (s_valid_i) begin
                    main_q <= s_data_i;
                end
            end
        end else if (s_valid_i && !skid_v_q) begin
            skid_q   <= s_data_i;
            skid_v_q <= 1'b1;
        end
    end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-level TLP TX arbiter: merges PORTS streams, locks a grant from sop to eop, round-robin.
// Define TLP_ARB_STRICT_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module tlp_tx_arbiter #(
    parameter  int PORTS        = 2,
    parameter  int DOUBLE_WORD  = 32,
    parameter  int HEADER_SIZE  = 4 * DOUBLE_WORD,
    parameter  int PAYLOAD_SIZE = 8 * DOUBLE_WORD,
    localparam int PORT_W       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*PAYLOAD_SIZE-1:0] in_data,
    input  logic [PORTS*HEADER_SIZE-1:0]  in_hdr,
    input  logic [PORTS-1:0]              in_sop,
    input  logic [PORTS-1:0]              in_eop,
    input  logic [PORTS-1:0]              in_valid,
    output logic [PORTS-1:0]              in_ready,
    output logic [PAYLOAD_SIZE-1:0]       out_data,
    output logic [HEADER_SIZE-1:0]        out_hdr,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PORT_W-1:0]             out_port,
    output logic                          err_drop
);

    import tlp_pkg::*;

    localparam int BEAT_W = HEADER_SIZE + PAYLOAD_SIZE + 2 + PORT_W;

    arb_state_e              state_q;
    logic [PORT_W-1:0]       grant_q;
    logic                    err_drop_q;

    logic [HEADER_SIZE-1:0]  hdr_a  [PORTS];
    logic [PAYLOAD_SIZE-1:0] data_a [PORTS];
    logic [PORTS-1:0]        cand;
    logic [PORTS-1:0]        drop;
    logic [PORTS-1:0]        rdy;
    logic                    found;
    logic [PORT_W-1:0]       win;
    logic [PORT_W-1:0]       idx;
    logic [PORT_W-1:0]       sel;
    logic                    room;
    logic                    push;
    logic                    pkt_done;
    logic [BEAT_W-1:0]       beat_in;
    logic [BEAT_W-1:0]       beat_out;

`ifndef TLP_ARB_STRICT_PRIO_EN
    localparam int SUM_W = PORT_W + 1;
    logic [PORT_W-1:0] rr_q;
    logic [SUM_W-1:0]  sum;
`endif

    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            hdr_a[i]  = in_hdr[i*HEADER_SIZE +: HEADER_SIZE];
            data_a[i] = in_data[i*PAYLOAD_SIZE +: PAYLOAD_SIZE];
        end
    end

    // First sop candidate scanning cyclically from the rr pointer (or from port 0).
    always_comb begin
        cand  = in_valid & in_sop;
        found = 1'b0;
        win   = '0;
        idx   = '0;
`ifndef TLP_ARB_STRICT_PRIO_EN
        sum   = '0;
`endif
        for (int unsigned k = 0; k < PORTS; k++) begin
`ifdef TLP_ARB_STRICT_PRIO_EN
            idx = PORT_W'(k);
`else
            sum = {1'b0, rr_q} + SUM_W'(k);
            if (sum >= SUM_W'(PORTS)) begin
                sum = sum - SUM_W'(PORTS);
            end
            idx = sum[PORT_W-1:0];
`endif
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel  = (state_q == ARB_LOCK) ? grant_q : win;
        push = (state_q == ARB_LOCK) ? (in_valid[grant_q] & room) : (found & room);
        pkt_done = push & in_eop[sel];
        drop = '0;
        rdy  = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (state_q == ARB_LOCK) begin
                drop[i] = in_valid[i] & ~in_sop[i] & (grant_q != PORT_W'(i));
                rdy[i]  = drop[i] | (room & (grant_q == PORT_W'(i)));
            end else begin
                drop[i] = in_valid[i] & ~in_sop[i];
                rdy[i]  = drop[i] | (room & found & (win == PORT_W'(i)));
            end
        end
        in_ready = rst ? '0 : rdy;
        beat_in  = {hdr_a[sel], data_a[sel], in_sop[sel], in_eop[sel], sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= |drop;
            unique case (state_q)
                ARB_IDLE: begin
                    if (push && !in_eop[sel]) begin
                        state_q <= ARB_LOCK;
                        grant_q <= sel;
                    end
                end
                ARB_LOCK: begin
                    if (pkt_done) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

`ifndef TLP_ARB_STRICT_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else if (pkt_done) begin
            rr_q <= (sel == PORT_W'(PORTS - 1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    tlp_skid_buf #(
        .W (BEAT_W)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (beat_in),
        .s_valid_i (push),
        .s_ready_o (room),
        .m_data_o  (beat_out),
        .m_valid_o (out_valid),
        .m_ready_i (out_ready)
    );

    assign {out_hdr, out_data, out_sop, out_eop, out_port} = beat_out;
    assign err_drop = err_drop_q;

endmodule
